alu_arbiter: RTL and testbench

- Shares the single 32-bit ALU (module alu: 00 ADD, 01 SUB, 10 AND, 11 OR) between two requesters, e.g. main datapath (req 0) and an iterative multiply/address unit (req 1).
- Valid/ready request handshake; round-robin arbitration; registered response stage with backpressure.
- Holds the architectural NZCV flags register, updated only by operations issued with setflags=1.

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu.sv | 24 ++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 72 +++++++
 tb/tb_alu_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: ALU opcodes, flag bit positions and the request bundle shared by the ALU arbiter
package alu_arb_pkg;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctrl;
        logic        setflags;
    } alu_req_t;
endpackage

// File: rtl/alu.sv
// alu: 32-bit ADD/SUB/AND/OR producing NZCV flags
module alu
    import alu_arb_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  ctrl,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    logic        sub;
    logic [32:0] sum;
    always_comb begin
        sub    = ctrl == ALU_SUB;
        // SUB is A + ~B + 1, so carry-out is the not-borrow
        sum    = {1'b0, a} + {1'b0, sub ? ~b : b} + {32'd0, sub};
        result = ctrl == ALU_AND ? a & b : ctrl == ALU_OR ? a | b : sum[31:0];
        flags  = '0;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = result == '0;
        flags[FLAG_C] = !ctrl[1] & sum[32];
        flags[FLAG_V] = !ctrl[1] & (a[31] == (b[31] ^ sub)) & (sum[31] != a[31]);
    end
endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input arbiter, round-robin or fixed priority to input 0
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr_q;
    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= 1'b0;
        else if (advance && RR_EN)
            ptr_q <= grant[0];
    end
    always_comb grant = &valid ? ((RR_EN && ptr_q) ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with a registered response and NZCV register
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter bit         RR_EN      = 1'b1,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_ctrl,
    input  logic        req0_setflags,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_ctrl,
    input  logic        req1_setflags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  flags_q
);
    alu_req_t    r0, r1, op;
    logic [1:0]  grant;
    logic        free, accept;
    logic [31:0] result;
    logic [3:0]  alu_flags;
    always_comb begin
        r0        = {req0_a, req0_b, req0_ctrl, req0_setflags};
        r1        = {req1_a, req1_b, req1_ctrl, req1_setflags};
        free      = !rsp_valid | rsp_ready;
        req_ready = grant & {2{free & !reset}};
        accept    = |(req_valid & req_ready);
        op        = req_ready[1] ? r1 : r0;
    end
    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant)
    );
    alu u_alu (
        .a      (op.a),
        .b      (op.b),
        .ctrl   (op.ctrl),
        .result (result),
        .flags  (alu_flags)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            flags_q    <= FLAG_RESET;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= req_ready[1];
            rsp_result <= result;
            rsp_flags  <= alu_flags;
            if (op.setflags)
                flags_q <= alu_flags;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors against a round-robin and a fixed-priority arbiter
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_ctrl, req1_ctrl;
    logic        req0_setflags, req1_setflags;
    logic        rsp_ready;
    logic [1:0]  req_ready, fp_req_ready;
    logic        rsp_valid, fp_rsp_valid;
    logic        rsp_id, fp_rsp_id;
    logic [31:0] rsp_result, fp_rsp_result;
    logic [3:0]  rsp_flags, fp_rsp_flags, flags_q, fp_flags_q;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1), .FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_setflags(req0_setflags),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_setflags(req1_setflags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags_q(flags_q)
    );

    alu_arbiter #(.RR_EN(1'b0), .FLAG_RESET(4'b1010)) dut_fp (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_setflags(req0_setflags),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_setflags(req1_setflags),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags), .flags_q(fp_flags_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b, input logic sf);
        req0_ctrl = ctrl; req0_a = a; req0_b = b; req0_setflags = sf;
    endtask

    task automatic set1(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b, input logic sf);
        req1_ctrl = ctrl; req1_a = a; req1_b = b; req1_setflags = sf;
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        set0(2'b00, 32'h0, 32'h0, 1'b0);
        set1(2'b00, 32'h0, 32'h0, 1'b0);
        tick(); tick();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_rsp_flags", rsp_flags, 4'h0);
        check("rst_flags_q", flags_q, 4'h0);
        check("rst_fp_flags_q", fp_flags_q, 4'b1010);

        reset = 1'b0; req_valid = 2'b01;
        set0(2'b00, 32'h000000FF, 32'h00000001, 1'b1);
        #1 check("add_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        check("add_valid", rsp_valid, 1'b1);
        check("add_id", rsp_id, 1'b0);
        check("add_result", rsp_result, 32'h00000100);
        check("add_flags", rsp_flags, 4'b0000);
        check("add_flags_q", flags_q, 4'b0000);

        req_valid = 2'b10;
        set1(2'b01, 32'h1, 32'h1, 1'b1);
        #1 check("sub_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        check("sub_id", rsp_id, 1'b1);
        check("sub_result", rsp_result, 32'h0);
        check("sub_flags", rsp_flags, 4'b0110);
        check("sub_flags_q", flags_q, 4'b0110);
        tick();
        check("retire_valid", rsp_valid, 1'b0);
        check("retire_hold", rsp_result, 32'h0);

        req_valid = 2'b01;
        set0(2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        tick();
        check("ovf_result", rsp_result, 32'h80000000);
        check("ovf_flags", rsp_flags, 4'b1001);
        check("ovf_flags_q", flags_q, 4'b1001);
        req_valid = 2'b10;
        set1(2'b10, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        tick();
        check("and_id", rsp_id, 1'b1);
        check("and_result", rsp_result, 32'h12345678);
        check("and_flags", rsp_flags, 4'b0000);
        check("and_flags_q", flags_q, 4'b1001);

        req_valid = 2'b11;
        set0(2'b00, 32'h1, 32'h1, 1'b0);
        set1(2'b11, 32'h10, 32'h1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 check("fp_ready1", fp_req_ready, 2'b01);
            tick();
            check("rr_id", rsp_id, i[0]);
            check("rr_result", rsp_result, i[0] ? 32'h11 : 32'h2);
            check("fp_id", fp_rsp_id, 1'b0);
        end

        rsp_ready = 1'b0;
        req0_setflags = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", req_ready, 2'b00);
            tick();
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_id", rsp_id, 1'b1);
            check("bp_result", rsp_result, 32'h11);
            check("bp_flags_q", flags_q, 4'b1001);
        end
        rsp_ready = 1'b1;
        #1 check("resume_ready", req_ready, 2'b01);
        tick();
        check("resume_id0", rsp_id, 1'b0);
        check("resume_res0", rsp_result, 32'h2);
        check("resume_flags_q", flags_q, 4'b0000);
        req0_setflags = 1'b0;
        #1 check("resume_ready1", req_ready, 2'b10);
        tick();
        check("resume_id1", rsp_id, 1'b1);
        check("resume_res1", rsp_result, 32'h11);

        set1(2'b01, 32'h0, 32'h1, 1'b1);
        tick();
        check("pre_id0", rsp_id, 1'b0);
        tick();
        check("neg_result", rsp_result, 32'hFFFFFFFF);
        check("neg_flags", rsp_flags, 4'b1000);
        tick();
        check("pre_rst_id", rsp_id, 1'b0);
        check("pre_rst_flags_q", flags_q, 4'b1000);

        reset = 1'b1;
        #1 check("mid_rst_ready", req_ready, 2'b00);
        tick();
        reset = 1'b0;
        check("mid_rst_valid", rsp_valid, 1'b0);
        check("mid_rst_flags_q", flags_q, 4'b0000);
        check("mid_rst_fp_flags_q", fp_flags_q, 4'b1010);
        #1 check("post_rst_ready", req_ready, 2'b01);
        tick();
        check("post_rst_id", rsp_id, 1'b0);
        check("post_rst_result", rsp_result, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
